// File: rtl/ttt_game_if.sv
// Player-facing request/acknowledge bundle of the tic-tac-toe controller.
// Handshake: a player raises req_x/req_o with its cell in pos_x/pos_o and holds both
// until move_ack or move_err pulses. Only the player named by turn is looked at.
// Each ack/err pulse answers the request seen on the edge before it.
interface ttt_game_if;
    logic       req_x;
    logic [3:0] pos_x;
    logic       req_o;
    logic [3:0] pos_o;
    logic [1:0] turn;
    logic       move_ack;
    logic       move_err;
    logic       timeout;

    modport master (
        output req_x, pos_x, req_o, pos_o,
        input  turn, move_ack, move_err, timeout
    );

    modport slave (
        input  req_x, pos_x, req_o, pos_o,
        output turn, move_ack, move_err, timeout
    );
endinterface

// File: rtl/ttt_game_controller.sv
// Runs one tic-tac-toe game: holds the board, enforces turn order and move legality,
// passes idle turns on timeout and reports win/draw from the external winner detector.
module ttt_game_controller #(
    parameter int TURN_TIMEOUT = 1000,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    ttt_game_if.slave  bus,
    input  logic       win,
    input  logic [1:0] who,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] result,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_X = 3'd1,
        TURN_O = 3'd2,
        CHECK  = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam int               TO_LAST_I = (TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

    state_t           state;
    logic [1:0]       board [9];
    logic [CNT_W-1:0] cnt;
    logic             mover_x;

    logic       req_cur;
    logic [3:0] pos_cur;
    logic       pos_ok;
    logic [3:0] idx;
    logic       legal;
    logic       to_hit;
    logic [1:0] my_code;

    always_comb begin
        req_cur = 1'b0;
        pos_cur = 4'd0;
        if (state == TURN_X) begin
            req_cur = bus.req_x;
            pos_cur = bus.pos_x;
        end else if (state == TURN_O) begin
            req_cur = bus.req_o;
            pos_cur = bus.pos_o;
        end
    end

    // idx is clamped so an illegal position never reads outside the board.
    assign pos_ok  = (pos_cur >= 4'd1) && (pos_cur <= 4'd9);
    assign idx     = pos_ok ? (pos_cur - 4'd1) : 4'd0;
    assign legal   = req_cur && pos_ok && (board[idx] == 2'b00);
    assign to_hit  = (TURN_TIMEOUT > 0) && (cnt == TO_LAST);
    assign my_code = (state == TURN_X) ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i < 9; i++) board[i] <= 2'b00;
            cnt          <= '0;
            mover_x      <= 1'b0;
            move_count   <= 4'd0;
            game_over    <= 1'b0;
            result       <= 2'b00;
            bus.turn     <= 2'b00;
            bus.move_ack <= 1'b0;
            bus.move_err <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            bus.move_ack <= 1'b0;
            bus.move_err <= 1'b0;
            bus.timeout  <= 1'b0;
            if (start) begin
                for (int i = 0; i < 9; i++) board[i] <= 2'b00;
                cnt        <= '0;
                move_count <= 4'd0;
                result     <= 2'b00;
                game_over  <= 1'b0;
                bus.turn   <= 2'b01;
                state      <= TURN_X;
            end else begin
                case (state)
                    TURN_X, TURN_O: begin
                        if (legal) begin
                            // An accepted move wins over a timeout in the same cycle.
                            board[idx]   <= my_code;
                            bus.move_ack <= 1'b1;
                            move_count   <= move_count + 4'd1;
                            mover_x      <= (state == TURN_X);
                            cnt          <= '0;
                            bus.turn     <= 2'b00;
                            state        <= CHECK;
                        end else begin
                            if (req_cur) bus.move_err <= 1'b1;
                            if (to_hit) begin
                                bus.timeout <= 1'b1;
                                cnt         <= '0;
                                if (state == TURN_X) begin
                                    bus.turn <= 2'b10;
                                    state    <= TURN_O;
                                end else begin
                                    bus.turn <= 2'b01;
                                    state    <= TURN_X;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        cnt <= '0;
                        if (win) begin
                            // The detector never reports both players; fall back to the mover if it does.
                            if (who == 2'b01 || who == 2'b10) result <= who;
                            else                              result <= mover_x ? 2'b01 : 2'b10;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (move_count == 4'd9) begin
                            result    <= 2'b11;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (mover_x) begin
                            bus.turn <= 2'b10;
                            state    <= TURN_O;
                        end else begin
                            bus.turn <= 2'b01;
                            state    <= TURN_X;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pos1      = board[0];
    assign pos2      = board[1];
    assign pos3      = board[2];
    assign pos4      = board[3];
    assign pos5      = board[4];
    assign pos6      = board[5];
    assign pos7      = board[6];
    assign pos8      = board[7];
    assign pos9      = board[8];
    assign state_dbg = state;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Directed bench for ttt_game_controller with a behavioural winner detector on the board.
module tb_ttt_game_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       win;
    logic [1:0] who;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] result;
    logic [2:0] state_dbg;
    int         n_cmp = 0;
    int         n_err = 0;

    ttt_game_if bus ();

    ttt_game_controller #(.TURN_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
        .win(win), .who(who),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .move_count(move_count), .game_over(game_over), .result(result),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Winner detector model: X cells are 10, O cells are 01; who reports 01=X, 10=O.
    logic [1:0] c [9];
    always_comb begin
        c = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
        win = 1'b0;
        who = 2'b00;
        for (int l = 0; l < 8; l++) begin
            int a, b, d;
            case (l)
                0: begin a = 0; b = 1; d = 2; end
                1: begin a = 3; b = 4; d = 5; end
                2: begin a = 6; b = 7; d = 8; end
                3: begin a = 0; b = 3; d = 6; end
                4: begin a = 1; b = 4; d = 7; end
                5: begin a = 2; b = 5; d = 8; end
                6: begin a = 0; b = 4; d = 8; end
                default: begin a = 2; b = 4; d = 6; end
            endcase
            if (c[a] != 2'b00 && c[a] == c[b] && c[a] == c[d]) begin
                win = 1'b1;
                who = (c[a] == 2'b10) ? 2'b01 : 2'b10;
            end
        end
    end

    function automatic logic [17:0] board_vec();
        return {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
    endfunction

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a request for one edge, then release it.
    task automatic drive_req(input bit is_x, input logic [3:0] p);
        if (is_x) begin bus.req_x = 1'b1; bus.pos_x = p; end
        else      begin bus.req_o = 1'b1; bus.pos_o = p; end
        tick();
        bus.req_x = 1'b0;
        bus.req_o = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        n_cmp++; if (board_vec() !== 18'd0) begin n_err++; $display("FAIL reset_board got %h want 0", board_vec()); end
        n_cmp++; if ({bus.turn, move_count, game_over, result} !== 9'd0) begin n_err++; $display("FAIL reset_outs got %h want 0", {bus.turn, move_count, game_over, result}); end
        n_cmp++; if ({bus.move_ack, bus.move_err, bus.timeout, state_dbg} !== 6'd0) begin n_err++; $display("FAIL reset_pulses got %h want 0", {bus.move_ack, bus.move_err, bus.timeout, state_dbg}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.turn !== 2'b00) begin n_err++; $display("FAIL idle_turn got %b want 00", bus.turn); end
    endtask

    task automatic test_x_wins();
        logic [3:0] seq [5];
        seq = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
        do_start();
        n_cmp++; if (bus.turn !== 2'b01) begin n_err++; $display("FAIL start_turn got %b want 01", bus.turn); end
        for (int i = 0; i < 5; i++) begin
            drive_req(i % 2 == 0, seq[i]);
            n_cmp++; if (bus.move_ack !== 1'b1) begin n_err++; $display("FAIL win_ack%0d got %b want 1", i, bus.move_ack); end
            n_cmp++; if (bus.turn !== 2'b00) begin n_err++; $display("FAIL win_check_turn%0d got %b want 00", i, bus.turn); end
            tick();
            if (i < 4) begin
                n_cmp++; if (bus.turn !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL win_next_turn%0d got %b", i, bus.turn); end
            end
        end
        n_cmp++; if ({game_over, result} !== 3'b101) begin n_err++; $display("FAIL win_result got %b want 101", {game_over, result}); end
        n_cmp++; if (board_vec() !== 18'b10_10_10_01_01_00_00_00_00) begin n_err++; $display("FAIL win_board got %b", board_vec()); end
        n_cmp++; if (move_count !== 4'd5) begin n_err++; $display("FAIL win_count got %0d want 5", move_count); end
        bus.req_x = 1'b1; bus.pos_x = 4'd7;
        bus.req_o = 1'b1; bus.pos_o = 4'd8;
        tick(3);
        n_cmp++; if ({bus.move_ack, bus.move_err, pos7, pos8, result, game_over} !== 9'b00_0000_011) begin n_err++; $display("FAIL over_frozen got %b want 000000011", {bus.move_ack, bus.move_err, pos7, pos8, result, game_over}); end
        bus.req_x = 1'b0; bus.req_o = 1'b0;
    endtask

    task automatic test_occupied();
        do_start();
        n_cmp++; if ({game_over, result, board_vec()} !== 21'd0) begin n_err++; $display("FAIL restart_clear got %h want 0", {game_over, result, board_vec()}); end
        drive_req(1'b1, 4'd5);
        tick();
        drive_req(1'b0, 4'd5);
        n_cmp++; if ({bus.move_err, bus.move_ack} !== 2'b10) begin n_err++; $display("FAIL occ_err got %b want 10", {bus.move_err, bus.move_ack}); end
        n_cmp++; if (pos5 !== 2'b10) begin n_err++; $display("FAIL occ_pos5 got %b want 10", pos5); end
        n_cmp++; if (bus.turn !== 2'b10) begin n_err++; $display("FAIL occ_turn got %b want 10", bus.turn); end
        drive_req(1'b0, 4'd1);
        n_cmp++; if ({bus.move_ack, bus.move_err, pos1} !== 4'b1001) begin n_err++; $display("FAIL occ_retry got %b want 1001", {bus.move_ack, bus.move_err, pos1}); end
        tick();
    endtask

    task automatic test_draw();
        logic [3:0] seq [9];
        seq = '{4'd5, 4'd1, 4'd9, 4'd3, 4'd2, 4'd8, 4'd4, 4'd6, 4'd7};
        do_start();
        for (int i = 0; i < 9; i++) begin
            drive_req(i % 2 == 0, seq[i]);
            n_cmp++; if (bus.move_ack !== 1'b1) begin n_err++; $display("FAIL draw_ack%0d got %b want 1", i, bus.move_ack); end
            tick();
        end
        n_cmp++; if ({game_over, result, move_count} !== 7'b1_11_1001) begin n_err++; $display("FAIL draw_result got %b want 1111001", {game_over, result, move_count}); end
        n_cmp++; if (board_vec() !== 18'b01_10_01_10_10_01_10_01_10) begin n_err++; $display("FAIL draw_board got %b", board_vec()); end
    endtask

    task automatic test_timeout();
        do_start();
        tick(7);
        n_cmp++; if ({bus.timeout, bus.turn} !== 3'b001) begin n_err++; $display("FAIL to_early got %b want 001", {bus.timeout, bus.turn}); end
        bus.req_o = 1'b1; bus.pos_o = 4'd1;
        tick();
        bus.req_o = 1'b0;
        n_cmp++; if ({bus.timeout, bus.turn, bus.move_ack} !== 4'b1100) begin n_err++; $display("FAIL to_pulse got %b want 1100", {bus.timeout, bus.turn, bus.move_ack}); end
        n_cmp++; if (board_vec() !== 18'd0) begin n_err++; $display("FAIL to_board got %h want 0", board_vec()); end
        tick();
        n_cmp++; if ({bus.timeout, bus.turn} !== 3'b010) begin n_err++; $display("FAIL to_single got %b want 010", {bus.timeout, bus.turn}); end
        drive_req(1'b0, 4'd1);
        n_cmp++; if ({bus.move_ack, pos1} !== 3'b101) begin n_err++; $display("FAIL to_o_move got %b want 101", {bus.move_ack, pos1}); end
        tick();
    endtask

    task automatic test_bad_pos_and_restart();
        bus.req_o = 1'b1; bus.pos_o = 4'd2;
        bus.req_x = 1'b1; bus.pos_x = 4'd0;
        tick();
        n_cmp++; if ({bus.move_err, bus.move_ack, pos2, bus.turn} !== 6'b10_00_01) begin n_err++; $display("FAIL pos0_err got %b want 100001", {bus.move_err, bus.move_ack, pos2, bus.turn}); end
        bus.req_o = 1'b0;
        bus.pos_x = 4'd10;
        tick();
        bus.req_x = 1'b0;
        n_cmp++; if ({bus.move_err, bus.move_ack, move_count} !== 6'b10_0001) begin n_err++; $display("FAIL pos10_err got %b want 100001", {bus.move_err, bus.move_ack, move_count}); end
        bus.req_x = 1'b1; bus.pos_x = 4'd3;
        do_start();
        bus.req_x = 1'b0;
        n_cmp++; if ({board_vec(), bus.turn, move_count, bus.move_ack} !== {18'd0, 2'b01, 4'd0, 1'b0}) begin n_err++; $display("FAIL restart_mid got %h", {board_vec(), bus.turn, move_count, bus.move_ack}); end
    endtask

    task automatic test_reset_in_check();
        drive_req(1'b1, 4'd1);
        n_cmp++; if (state_dbg !== 3'd3) begin n_err++; $display("FAIL in_check got %0d want 3", state_dbg); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({board_vec(), bus.turn, move_count, bus.move_ack, state_dbg} !== 28'd0) begin n_err++; $display("FAIL rst_check got %h want 0", {board_vec(), bus.turn, move_count, bus.move_ack, state_dbg}); end
        rst_n = 1'b1;
        bus.req_x = 1'b1; bus.pos_x = 4'd2;
        tick(3);
        bus.req_x = 1'b0;
        n_cmp++; if ({bus.move_ack, bus.move_err, pos2, bus.turn} !== 6'd0) begin n_err++; $display("FAIL post_rst_ignore got %b want 0", {bus.move_ack, bus.move_err, pos2, bus.turn}); end
    endtask

    initial begin
        bus.req_x = 1'b0; bus.pos_x = 4'd0;
        bus.req_o = 1'b0; bus.pos_o = 4'd0;
        test_reset();
        test_x_wins();
        test_occupied();
        test_draw();
        test_timeout();
        test_bad_pos_and_restart();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
